ram_burst_reader: RTL and testbench

Read-side initiator for the single-port RAM. On a start command it walks a contiguous, wrapping address range, fetches one word per cycle over the RAM's combinational read port, and delivers the words as a valid/ready stream with a last-beat marker. It sits between the RAM and any downstream consumer, such as a UART transmitter or checksum unit. It holds full throughput under continuous ready and stalls cleanly under backpressure.

---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_addr_wrap_counter.sv | 26 ++
 rtl/ram_burst_reader.sv | 114 +++++++++++
 tb/tb_ram_burst_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared RAM geometry, address-width helper and burst reader state encoding.
package ram_pkg;

   // Bits needed to represent value; never less than one.
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned v;
      int unsigned w;
      v = value;
      w = 0;
      while (v > 0) begin
         w++;
         v = v >> 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned DEPTH      = 8;
   localparam int unsigned ADDR_WIDTH = clogb2(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

endpackage

// File: rtl/ram_addr_wrap_counter.sv
// Loadable address pointer that wraps from DEPTH-1 back to zero.
module ram_addr_wrap_counter #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] load_val_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] count_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_o <= '0;
      end else if (load_i) begin
         count_o <= load_val_i;
      end else if (inc_i) begin
         count_o <= (count_o == LAST_ADDR) ? '0 : count_o + 1'b1;
      end
   end

endmodule

// File: rtl/ram_burst_reader.sv
// Walks a wrapping RAM address range and streams one word per cycle with
// valid/ready handshake and a last-beat marker.
module ram_burst_reader #(
   parameter int unsigned DATA_WIDTH = ram_pkg::DATA_WIDTH,
   parameter int unsigned DEPTH      = ram_pkg::DEPTH,
   parameter int unsigned ADDR_WIDTH = ram_pkg::clogb2(DEPTH - 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] start_addr_i,
   input  logic [ADDR_WIDTH:0]   length_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   output logic                  m_last_o,
   input  logic                  m_ready_i
);

   import ram_pkg::*;

   localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_LEN   = (ADDR_WIDTH + 1)'(1);

   state_e              state_q, state_d;
   logic [ADDR_WIDTH:0] remaining_q;
   logic [ADDR_WIDTH:0] length_clamped;
   logic                load, fetch, drain_pop, done_d, err_d;

   assign length_clamped = (length_i > DEPTH_LEN) ? DEPTH_LEN : length_i;
   assign busy_o         = (state_q != IDLE);

   ram_addr_wrap_counter #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ptr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (load),
      .load_val_i (start_addr_i),
      .inc_i      (fetch),
      .count_o    (ram_addr_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      fetch     = 1'b0;
      drain_pop = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (32'(start_addr_i) >= DEPTH) begin
                  err_d = 1'b1;
               end else if (length_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Refill whenever the output register is empty or being drained.
            fetch = !m_valid_o || m_ready_i;
            if (fetch && remaining_q == ONE_LEN) state_d = DRAIN;
         end
         DRAIN: begin
            if (m_valid_o && m_ready_i) begin
               drain_pop = 1'b1;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         remaining_q <= '0;
         m_data_o    <= '0;
         m_valid_o   <= 1'b0;
         m_last_o    <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         done_o <= done_d;
         err_o  <= err_d;
         if (load) remaining_q <= length_clamped;
         if (fetch) begin
            m_data_o    <= ram_rd_data_i;
            m_valid_o   <= 1'b1;
            m_last_o    <= (remaining_q == ONE_LEN);
            remaining_q <= remaining_q - 1'b1;
         end else if (drain_pop) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed scoreboard bench for ram_burst_reader against a combinational-read RAM model.
module tb_ram_burst_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] start_addr = '0;
   logic [3:0] length = '0;
   logic       busy, done, err;
   logic [2:0] ram_addr;
   logic [7:0] ram_rd;
   logic [7:0] m_data;
   logic       m_valid, m_last;
   logic       m_ready = 1'b1;

   logic       start6 = 1'b0;
   logic [2:0] start_addr6 = '0;
   logic [3:0] length6 = '0;
   logic       busy6, done6, err6;
   logic [2:0] ram_addr6;
   logic [7:0] ram_rd6;
   logic [7:0] m_data6;
   logic       m_valid6, m_last6;

   logic [7:0] mem [0:7];
   assign ram_rd  = mem[ram_addr];
   assign ram_rd6 = mem[ram_addr6];

   always #5 clk = ~clk;

   ram_burst_reader #(
      .DATA_WIDTH (8),
      .DEPTH      (8),
      .ADDR_WIDTH (3)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .start_addr_i  (start_addr),
      .length_i      (length),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err),
      .ram_addr_o    (ram_addr),
      .ram_rd_data_i (ram_rd),
      .m_data_o      (m_data),
      .m_valid_o     (m_valid),
      .m_last_o      (m_last),
      .m_ready_i     (m_ready)
   );

   ram_burst_reader #(
      .DATA_WIDTH (8),
      .DEPTH      (6),
      .ADDR_WIDTH (3)
   ) dut6 (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start6),
      .start_addr_i  (start_addr6),
      .length_i      (length6),
      .busy_o        (busy6),
      .done_o        (done6),
      .err_o         (err6),
      .ram_addr_o    (ram_addr6),
      .ram_rd_data_i (ram_rd6),
      .m_data_o      (m_data6),
      .m_valid_o     (m_valid6),
      .m_last_o      (m_last6),
      .m_ready_i     (1'b1)
   );

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   int unsigned done_cnt = 0;
   int unsigned beat_cnt = 0;
   int unsigned valid_cycles  = 0;
   int unsigned valid6_cycles = 0;
   logic [8:0]  sb [$];

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   logic       prev_last  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: scores handshakes against the queue and checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (m_valid)  valid_cycles++;
         if (m_valid6) valid6_cycles++;
         if (done) begin
            done_cnt++;
            check("busy_low_with_done", 32'(busy), 32'd0);
         end
         if (prev_stall) begin
            check("stall_valid_held", 32'(m_valid), 32'd1);
            check("stall_data_held", 32'(m_data), 32'(prev_data));
            check("stall_last_held", 32'(m_last), 32'(prev_last));
         end
         if (m_valid && m_ready) begin
            n_assert++;
            assert (sb.size() != 0) else begin
               n_fail++;
               $error("FAIL spurious_beat: observed data %0h expected no beat", m_data);
            end
            if (sb.size() != 0) begin
               logic [8:0] e;
               e = sb.pop_front();
               check("beat_data", 32'(m_data), 32'(e[7:0]));
               check("beat_last", 32'(m_last), 32'(e[8]));
               beat_cnt++;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic burst(input int unsigned addr, input int unsigned len,
                        input logic [15:0] pat, input int unsigned plen,
                        input int restart_at);
      int unsigned n;
      int unsigned pidx;
      int unsigned d0;
      int unsigned v0;
      n    = (len > 8) ? 8 : len;
      pidx = 0;
      for (int unsigned i = 0; i < n; i++) begin
         logic [8:0] e;
         e[7:0] = mem[(addr + i) % 8];
         e[8]   = (i == n - 1);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start_addr = addr[2:0];
      length     = len[3:0];
      start      = 1'b1;
      m_ready    = 1'b1;
      d0 = done_cnt;
      v0 = valid_cycles;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'(n > 0));
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (cyc == 1) check("first_valid_latency", 32'(m_valid), 32'(n > 0));
         if (done_cnt != d0) break;
         if (cyc == restart_at) begin
            start      = 1'b1;
            start_addr = 3'd5;
            length     = 4'd3;
         end else begin
            start = 1'b0;
         end
         if (m_valid) begin
            m_ready = (pidx < plen) ? pat[pidx] : 1'b1;
            pidx++;
         end else begin
            m_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      start   = 1'b0;
      m_ready = 1'b1;
      check("done_reached", done_cnt - d0, 32'd1);
      check("scoreboard_empty", sb.size(), 32'd0);
      if (plen == 0) check("valid_cycles", valid_cycles - v0, n);
      repeat (3) @(posedge clk);
      #1;
      check("done_single_pulse", done_cnt - d0, 32'd1);
      check("idle_after_burst", 32'(busy), 32'd0);
   endtask

   initial begin
      int unsigned b0;
      for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_last", 32'(m_last), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      check("rst_err6", 32'(err6), 32'd0);
      rst = 1'b0;

      burst(2, 4, 16'h0000, 0, -1);
      burst(6, 4, 16'h0000, 0, -1);
      burst(6, 4, 16'h0069, 7, -1);
      burst(0, 0, 16'h0000, 0, -1);
      burst(0, 9, 16'h0000, 0, -1);
      burst(1, 5, 16'h0000, 0, 2);

      for (int unsigned i = 0; i < 8; i++) sb.push_back({(i == 7), mem[i]});
      @(posedge clk); #1;
      start_addr = 3'd0;
      length     = 4'd8;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      b0 = beat_cnt;
      for (int c = 0; c < 50 && (beat_cnt - b0) < 2; c++) @(negedge clk);
      check("beats_before_reset", beat_cnt - b0, 32'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_valid", 32'(m_valid), 32'd0);
      check("midrst_last", 32'(m_last), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_addr", 32'(ram_addr), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      sb.delete();
      rst = 1'b0;
      burst(0, 2, 16'h0000, 0, -1);

      @(posedge clk); #1;
      start_addr6 = 3'd7;
      length6     = 4'd2;
      start6      = 1'b1;
      @(posedge clk); #1;
      start6 = 1'b0;
      check("dut6_err_pulse", 32'(err6), 32'd1);
      check("dut6_busy", 32'(busy6), 32'd0);
      @(posedge clk); #1;
      check("dut6_err_cleared", 32'(err6), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("dut6_no_beats", valid6_cycles, 32'd0);
      check("dut6_no_done", 32'(done6), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
